// File: rtl/cpu_pkg.sv
// Shared CPU definitions: data-path width, instruction field positions,
// ALU opcodes (shared with the ALU) and the ID/EX pipeline bundle.
package cpu_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned NREGS  = 32;
  localparam int unsigned IMM_W  = 13;
  localparam int unsigned REG_AW = 5;

  // Instruction word layout
  localparam int unsigned OpMsb     = 31;
  localparam int unsigned OpLsb     = 29;
  localparam int unsigned ImmSelBit = 28;
  localparam int unsigned RdMsb     = 27;
  localparam int unsigned RdLsb     = 23;
  localparam int unsigned Rs1Msb    = 22;
  localparam int unsigned Rs1Lsb    = 18;
  localparam int unsigned Rs2Msb    = 17;
  localparam int unsigned Rs2Lsb    = 13;
  localparam int unsigned ImmMsb    = 12;
  localparam int unsigned ImmLsb    = 0;

  typedef enum logic [2:0] {
    AluAdd = 3'd0,
    AluSub = 3'd1,
    AluAnd = 3'd2,
    AluOr  = 3'd3,
    AluXor = 3'd4,
    AluSll = 3'd5,
    AluSrl = 3'd6,
    AluSra = 3'd7
  } alu_op_e;

  typedef struct packed {
    logic              valid;
    logic [XLEN-1:0]   rs1_data;
    logic [XLEN-1:0]   rs2_data;
    alu_op_e           alu_op;
    logic [REG_AW-1:0] rd;
    logic              reg_write;
    logic              imm_sel;
  } id_ex_t;

  function automatic logic [XLEN-1:0] sext_imm(input logic [IMM_W-1:0] imm);
    return {{(XLEN - IMM_W){imm[IMM_W-1]}}, imm};
  endfunction

endpackage

// File: rtl/regfile.sv
// Integer register file: two combinational read ports, one write port.
// x0 is hardwired to zero; a write in flight is bypassed to matching reads.
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset (inhibits write)
//   raddr_a_i/raddr_b_i   read addresses; rdata_a_o/rdata_b_o read data
//   we_i, waddr_i, wdata_i write port
module regfile
  import cpu_pkg::*;
#(
  parameter int unsigned Width   = XLEN,
  parameter int unsigned NumRegs = NREGS,
  parameter int unsigned AddrW   = REG_AW
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [AddrW-1:0] raddr_a_i,
  input  logic [AddrW-1:0] raddr_b_i,
  output logic [Width-1:0] rdata_a_o,
  output logic [Width-1:0] rdata_b_o,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [Width-1:0] wdata_i
);

  // Not reset: contents are undefined until written.
  logic [Width-1:0] mem_q [NumRegs];
  logic             wr_live;

  assign wr_live = we_i && (waddr_i != '0);

  always_ff @(posedge clk_i) begin
    if (!rst_i && wr_live) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_comb begin
    rdata_a_o = '0;
    if (raddr_a_i != '0) begin
      rdata_a_o = (wr_live && (waddr_i == raddr_a_i)) ? wdata_i : mem_q[raddr_a_i];
    end
  end

  always_comb begin
    rdata_b_o = '0;
    if (raddr_b_i != '0) begin
      rdata_b_o = (wr_live && (waddr_i == raddr_b_i)) ? wdata_i : mem_q[raddr_b_i];
    end
  end

endmodule

// File: rtl/decode_stage.sv
// Instruction-decode stage: field extraction, register-file read, immediate
// substitution for operand B, and the ID/EX pipeline register.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   in_valid, instr              incoming instruction
//   stall, flush                 hold / bubble the ID/EX register (flush wins)
//   wb_en, wb_addr, wb_data      writeback into the register file
//   ex_valid, rs1_data, rs2_data, alu_op, rd, reg_write, imm_sel_q  ID/EX outputs
module decode_stage
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [31:0]       instr,
  input  logic              stall,
  input  logic              flush,
  input  logic              wb_en,
  input  logic [REG_AW-1:0] wb_addr,
  input  logic [XLEN-1:0]   wb_data,
  output logic              ex_valid,
  output logic [XLEN-1:0]   rs1_data,
  output logic [XLEN-1:0]   rs2_data,
  output logic [2:0]        alu_op,
  output logic [REG_AW-1:0] rd,
  output logic              reg_write,
  output logic              imm_sel_q
);

  logic [REG_AW-1:0] rs1_addr, rs2_addr, rd_addr;
  logic [IMM_W-1:0]  imm;
  logic              imm_sel;
  logic [XLEN-1:0]   rs1_rd, rs2_rd;
  id_ex_t            id_ex_d, id_ex_q;

  assign rs1_addr = instr[Rs1Msb:Rs1Lsb];
  assign rs2_addr = instr[Rs2Msb:Rs2Lsb];
  assign rd_addr  = instr[RdMsb:RdLsb];
  assign imm      = instr[ImmMsb:ImmLsb];
  assign imm_sel  = instr[ImmSelBit];

  regfile u_regfile (
    .clk_i     (clk),
    .rst_i     (rst),
    .raddr_a_i (rs1_addr),
    .raddr_b_i (rs2_addr),
    .rdata_a_o (rs1_rd),
    .rdata_b_o (rs2_rd),
    .we_i      (wb_en),
    .waddr_i   (wb_addr),
    .wdata_i   (wb_data)
  );

  always_comb begin
    id_ex_d = id_ex_q;
    if (flush) begin
      id_ex_d = '0;
    end else if (!stall) begin
      id_ex_d.valid     = in_valid;
      id_ex_d.rs1_data  = rs1_rd;
      id_ex_d.rs2_data  = imm_sel ? sext_imm(imm) : rs2_rd;
      id_ex_d.alu_op    = alu_op_e'(instr[OpMsb:OpLsb]);
      id_ex_d.rd        = rd_addr;
      id_ex_d.reg_write = in_valid && (rd_addr != '0);
      id_ex_d.imm_sel   = imm_sel;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      id_ex_q <= '0;
    end else begin
      id_ex_q <= id_ex_d;
    end
  end

  assign ex_valid  = id_ex_q.valid;
  assign rs1_data  = id_ex_q.rs1_data;
  assign rs2_data  = id_ex_q.rs2_data;
  assign alu_op    = id_ex_q.alu_op;
  assign rd        = id_ex_q.rd;
  assign reg_write = id_ex_q.reg_write;
  assign imm_sel_q = id_ex_q.imm_sel;

endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;
  import cpu_pkg::*;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] instr;
  logic        stall;
  logic        flush;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        ex_valid;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [2:0]  alu_op;
  logic [4:0]  rd;
  logic        reg_write;
  logic        imm_sel_q;

  decode_stage dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .instr     (instr),
    .stall     (stall),
    .flush     (flush),
    .wb_en     (wb_en),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .ex_valid  (ex_valid),
    .rs1_data  (rs1_data),
    .rs2_data  (rs2_data),
    .alu_op    (alu_op),
    .rd        (rd),
    .reg_write (reg_write),
    .imm_sel_q (imm_sel_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [31:0] regs [32];
  id_ex_t      model_q;
  id_ex_t      sb [$];
  int          n_cmp = 0;
  int          n_mis = 0;
  int          cyc   = 0;

  function automatic logic [31:0] mk(input int op, input int isel, input int rdi,
                                     input int r1, input int r2, input int im);
    logic [31:0] w;
    w = 32'(op & 7) << 29;
    w = w | (32'(isel & 1) << 28);
    w = w | (32'(rdi & 31) << 23);
    w = w | (32'(r1 & 31) << 18);
    w = w | (32'(r2 & 31) << 13);
    w = w | 32'(im & 13'h1FFF);
    return w;
  endfunction

  // Architectural read as seen by an instruction in the same cycle as a writeback.
  function automatic logic [31:0] arch_read(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (wb_en && wb_addr == a) return wb_data;
    return regs[a];
  endfunction

  function automatic void model_step();
    id_ex_t     n;
    logic [12:0] im;
    n = model_q;
    if (rst || flush) begin
      n = '0;
    end else if (!stall) begin
      im          = instr[12:0];
      n.valid     = in_valid;
      n.rs1_data  = arch_read(instr[22:18]);
      n.rs2_data  = instr[28] ? {{19{im[12]}}, im} : arch_read(instr[17:13]);
      n.alu_op    = alu_op_e'(instr[31:29]);
      n.rd        = instr[27:23];
      n.reg_write = in_valid && (instr[27:23] != 5'd0);
      n.imm_sel   = instr[28];
    end
    sb.push_back(n);
    model_q = n;
    if (!rst && wb_en && wb_addr != 5'd0) regs[wb_addr] = wb_data;
  endfunction

  task automatic drive(input logic r, input logic iv, input logic [31:0] ins,
                       input logic st, input logic fl, input logic we,
                       input logic [4:0] wa, input logic [31:0] wd);
    rst = r; in_valid = iv; instr = ins; stall = st; flush = fl;
    wb_en = we; wb_addr = wa; wb_data = wd;
    @(posedge clk);
    model_step();
    cyc++;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
  endtask

  // Monitor: one ID/EX snapshot per cycle, sampled mid-cycle.
  always @(negedge clk) begin
    id_ex_t act, e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      act.valid     = ex_valid;
      act.rs1_data  = rs1_data;
      act.rs2_data  = rs2_data;
      act.alu_op    = alu_op_e'(alu_op);
      act.rd        = rd;
      act.reg_write = reg_write;
      act.imm_sel   = imm_sel_q;
      n_cmp++;
      if (act !== e) begin
        n_mis++;
        $display("FAIL idex cyc=%0d got v=%b a=%h b=%h op=%0d rd=%0d rw=%b is=%b exp v=%b a=%h b=%h op=%0d rd=%0d rw=%b is=%b",
                 cyc, act.valid, act.rs1_data, act.rs2_data, act.alu_op, act.rd,
                 act.reg_write, act.imm_sel, e.valid, e.rs1_data, e.rs2_data, e.alu_op,
                 e.rd, e.reg_write, e.imm_sel);
      end
    end
  end

  initial begin
    model_q = '0;
    for (int i = 0; i < 32; i++) regs[i] = 32'd0;

    // Reset with valid instruction and a writeback that must be inhibited
    drive(1'b1, 1'b1, $urandom, 1'b0, 1'b0, 1'b1, 5'd3, 32'hAAAA_5555);
    drive(1'b1, 1'b1, $urandom, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);

    // Populate every register while only x0 is read
    for (int i = 1; i < 32; i++) begin
      drive(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 5'(i), $urandom);
    end

    // Write then read
    drive(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 5'd5, 32'h0000_1234);
    drive(1'b0, 1'b1, mk(2, 0, 7, 5, 0, 0), 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);

    // Same-cycle bypass, then a write to x0 that must not bypass
    drive(1'b0, 1'b1, mk(1, 0, 4, 9, 9, 0), 1'b0, 1'b0, 1'b1, 5'd9, 32'hDEAD_BEEF);
    drive(1'b0, 1'b1, mk(1, 0, 4, 0, 0, 0), 1'b0, 1'b0, 1'b1, 5'd0, 32'hDEAD_BEEF);

    // Immediates at the sign boundary
    drive(1'b0, 1'b1, mk(3, 1, 1, 2, 6, 13'h1FFF), 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    drive(1'b0, 1'b1, mk(3, 1, 1, 2, 6, 13'h0FFF), 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);

    // Stall holds A, stall+flush bubbles, release loads the new instruction
    drive(1'b0, 1'b1, mk(5, 0, 12, 3, 4, 0), 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, $urandom, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    end
    drive(1'b0, 1'b1, $urandom, 1'b1, 1'b1, 1'b0, 5'd0, 32'd0);
    drive(1'b0, 1'b1, mk(6, 0, 13, 7, 8, 0), 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);

    // rd = 0 and x0 write
    drive(1'b0, 1'b1, mk(0, 0, 0, 5, 9, 0), 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    drive(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF);
    drive(1'b0, 1'b1, mk(4, 0, 2, 0, 0, 0), 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    idle();

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 49) == 0), 1'($urandom), $urandom,
            ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0),
            1'($urandom), 5'($urandom), $urandom);
    end
    idle();

    // Let the monitor drain the scoreboard; anything left is a missed check
    for (int i = 0; i < 4 && sb.size() > 0; i++) @(negedge clk);
    #1;
    if (sb.size() > 0) begin
      n_mis++;
      $display("FAIL drain: %0d entries left, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Instruction-decode stage: decodes a 32-bit instruction word, reads the integer register file, and optionally substitutes a sign-extended immediate for the second operand.
- Registers operands and control into the ID/EX pipeline register, which drives the execute stage's rs1_data, rs2_data and alu_op inputs.
- Owns the architectural register file. Accepts the writeback port from the end of the pipeline, with same-cycle write-to-read bypass.

Parameters:
- XLEN, 32, data path width.
- NREGS, 32, number of architectural registers; x0 reads as zero.
- IMM_W, 13, immediate field width, sign-extended to XLEN.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  instr holds a valid instruction this cycle.
- instr  in  32  instruction word.
- stall  in  1  hold the ID/EX register contents.
- flush  in  1  insert a bubble into the ID/EX register.
- wb_en  in  1  register-file write enable.
- wb_addr  in  5  write destination.
- wb_data  in  XLEN  write data.
- ex_valid  out  1  ID/EX entry is valid.
- rs1_data  out  XLEN  operand A.
- rs2_data  out  XLEN  operand B, either register or immediate.
- alu_op  out  3  ALU opcode.
- rd  out  5  destination register.
- reg_write  out  1  entry writes rd (rd≠0 and valid).
- imm_sel_q  out  1  registered immediate-select, for debug and hazard logic.

Behaviour:
- Instruction fields:
  - [31:29] alu_op
  - [28] imm_sel
  - [27:23] rd
  - [22:18] rs1
  - [17:13] rs2
  - [12:0] imm, sign-extended from bit 12
- Register file:
  - NREGS×XLEN array with two combinational read ports and one write port, written on clk when wb_en=1 and wb_addr≠0.
  - Writes to x0 are discarded. Reads of x0 return 0 regardless of any write.
  - Read bypass: if wb_en=1, wb_addr≠0 and wb_addr equals a read address, that read returns wb_data in the same cycle.
  - The register array is not cleared by rst; contents are undefined until written, except x0.
- Operand B: rs2_data_next = imm_sel ? sext(imm) : read(rs2). When imm_sel=1 the rs2 field is ignored.
- ID/EX register, priority is rst > flush > stall > load:
  - rst: ex_valid, rs1_data, rs2_data, alu_op, rd, reg_write and imm_sel_q all go to 0.
  - flush: ex_valid=0 and reg_write=0. Other fields take don't-care values; the implementation drives them to 0.
  - stall (no flush): all outputs hold their values, and a concurrent wb write still updates the array.
  - load: ex_valid←in_valid; reg_write←in_valid & (rd≠0); all other fields are loaded from the decode of instr.
- Latency: one cycle from instr to outputs.
- The writeback port is never gated by stall, flush or in_valid. It is gated only by rst, which inhibits the write in its cycle.
- When stall=1 the upstream fetch holds instr. The block does not buffer a second instruction.
- Operands captured while stalled are not refreshed. Writes landing during a stall are the upstream hazard logic's responsibility, which must flush or replay. This is documented, not handled.
- in_valid=0 loads a bubble (ex_valid=0, reg_write=0). Data fields still load from instr.

Decomposition:
- Shared package cpu_pkg holds:
  - XLEN
  - field bit positions
  - ALU opcode constants, 3-bit, shared with the ALU
  - a typedef for the ID/EX bundle (valid, rs1_data, rs2_data, alu_op, rd, reg_write, imm_sel)
- One sub-module, regfile: 2R/1W array with x0 handling and write-to-read bypass.
- decode_stage holds the field extraction, immediate mux and ID/EX register.

Test Plan:
- Reset, then idle: hold rst=1 for 2 cycles with in_valid=1 and arbitrary instr -> all outputs 0 during reset and on the first cycle after.
- Write/read: wb write x5=0x0000_1234. Next cycle present alu_op=2, rs1=5, rs2=0, imm_sel=0, rd=7 -> one cycle later rs1_data=0x1234, rs2_data=0, alu_op=2, rd=7, reg_write=1, ex_valid=1.
- Bypass: in the same cycle, wb x9=0xDEAD_BEEF and present an instr with rs1=9, rs2=9 -> next cycle rs1_data=rs2_data=0xDEADBEEF. Repeat with wb_addr=0 -> operands read 0.
- Immediate: imm_sel=1, imm=0x1FFF -> rs2_data=0xFFFF_FFFF. imm=0x0FFF -> rs2_data=0x0000_0FFF.
- Stall/flush:
  - Load instr A, then assert stall for 3 cycles while changing instr -> outputs stay at A.
  - Assert stall and flush together -> ex_valid=0, reg_write=0.
  - Then deassert both -> the new instr loads.
- rd=0 handling: in_valid=1, rd=0 -> ex_valid=1, reg_write=0. A wb to x0 with 0xFFFF_FFFF, then a read of x0 -> 0.
